// File: rtl/fasm_init_pkg.sv
// Shared types for the FASM bus initiator: data width, FSM states and queued command.
package fasm_init_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  // Counter width able to hold values 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/fasm_cmd_fifo.sv
// Synchronous command queue, FIFO_DEPTH x cmd_t, first-word-fall-through head.
// The head is read combinationally so the FSM can pop and load the bus in one edge;
// the queue is tiny, so the storage maps to LUT RAM rather than block RAM.
module fasm_cmd_fifo
  import fasm_init_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/fasm_bus_initiator.sv
// FASM register-bus initiator: queues commands, runs one stb/ack transaction at a time
// and returns read data, write completion or an ack-timeout error.
// Optional feature macro: DEBUG_HEARTBEAT_EN (periodic heartbeat write, sticky hb_fail).
module fasm_bus_initiator
  import fasm_init_pkg::*;
#(
  parameter int                    FIFO_DEPTH       = 4,
  parameter int                    ACK_TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0] HEARTBEAT_ADDR   = '0,
  parameter int                    HEARTBEAT_PERIOD = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] adr_wr_o,
  output logic [DATA_WIDTH-1:0] adr_rd_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  output logic                  busy,
  output logic                  hb_fail
);

  localparam int            TW       = cnt_width(ACK_TIMEOUT);
  localparam logic [TW-1:0] TO_LIMIT = TW'(ACK_TIMEOUT);

  state_e        state_q;
  logic [TW-1:0] to_cnt_q;
  logic [TW-1:0] to_cnt_d;
  logic          to_expire;

  cmd_t          push_cmd;
  cmd_t          head_cmd;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  logic          hb_issue;
  logic          rsp_suppress;

  assign push_cmd   = '{we: cmd_we, addr: cmd_addr, data: cmd_data};
  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_q == IDLE) && !hb_issue && !fifo_empty;
  assign busy       = (state_q != IDLE) || !fifo_empty;

  assign to_cnt_d   = to_cnt_q + 1'b1;
  // A zero limit disables the timeout entirely.
  assign to_expire  = (ACK_TIMEOUT != 0) && (to_cnt_d == TO_LIMIT);

  fasm_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .head_o      (head_cmd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef DEBUG_HEARTBEAT_EN
  localparam int            HW      = cnt_width(HEARTBEAT_PERIOD - 1);
  localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_PERIOD - 1);

  logic [HW-1:0] hb_cnt_q;
  logic          hb_wrap;
  logic          hb_pending_q;
  logic          hb_active_q;
  logic          hb_fail_q;

  assign hb_wrap      = (hb_cnt_q == HB_LAST);
  assign hb_issue     = (state_q == IDLE) && hb_pending_q;
  assign rsp_suppress = hb_active_q;
  assign hb_fail      = hb_fail_q;

  // Free-running heartbeat period counter.
  always_ff @(posedge clk) begin
    if (reset)        hb_cnt_q <= '0;
    else if (hb_wrap) hb_cnt_q <= '0;
    else              hb_cnt_q <= hb_cnt_q + 1'b1;
  end

  // Single pending kick: a wrap while already pending merges into the same kick.
  always_ff @(posedge clk) begin
    if (reset)         hb_pending_q <= 1'b0;
    else if (hb_wrap)  hb_pending_q <= 1'b1;
    else if (hb_issue) hb_pending_q <= 1'b0;
  end

  // Marks the in-flight transaction as a heartbeat so its response is swallowed.
  always_ff @(posedge clk) begin
    if (reset)         hb_active_q <= 1'b0;
    else if (hb_issue) hb_active_q <= 1'b1;
    else if (fifo_pop) hb_active_q <= 1'b0;
  end

  // Sticky failure flag when a heartbeat kick is never acknowledged.
  always_ff @(posedge clk) begin
    if (reset)
      hb_fail_q <= 1'b0;
    else if ((state_q == BUS) && !ack_i && to_expire && hb_active_q)
      hb_fail_q <= 1'b1;
  end
`else
  logic unused_hb_cfg;

  assign hb_issue      = 1'b0;
  assign rsp_suppress  = 1'b0;
  assign hb_fail       = 1'b0;
  assign unused_hb_cfg = ^{HEARTBEAT_ADDR, HEARTBEAT_PERIOD};
`endif

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_wr_o  <= '0;
      adr_rd_o  <= '0;
      dat_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hb_issue) begin
            we_o     <= 1'b1;
            adr_wr_o <= HEARTBEAT_ADDR;
            adr_rd_o <= HEARTBEAT_ADDR;
            dat_o    <= '0;
            stb_o    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= BUS;
          end else if (!fifo_empty) begin
            we_o     <= head_cmd.we;
            adr_wr_o <= head_cmd.addr;
            adr_rd_o <= head_cmd.addr;
            dat_o    <= head_cmd.we ? head_cmd.data : '0;
            stb_o    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= BUS;
          end
        end
        BUS: begin
          if (ack_i) begin
            stb_o     <= 1'b0;
            rsp_valid <= !rsp_suppress;
            rsp_data  <= we_o ? '0 : dat_i;
            rsp_err   <= 1'b0;
            state_q   <= RESP;
          end else begin
            to_cnt_q <= to_cnt_d;
            if (to_expire) begin
              stb_o     <= 1'b0;
              rsp_valid <= !rsp_suppress;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              state_q   <= RESP;
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
